// File: rtl/vx_div_pool.sv
// Multi-unit radix-2 restoring divide pool with RISC-V M semantics.
// Results leave in issue order through an index FIFO; units that finish early wait in DONE.
module vx_div_pool #(
  parameter int XLEN      = 32,
  parameter int NUM_LANES = 4,
  parameter int NUM_UNITS = 2,
  parameter int TAG_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      valid_in,
  output logic                      ready_in,
  input  logic                      is_signed_in,
  input  logic                      is_rem_in,
  input  logic [NUM_LANES*XLEN-1:0] numer_in,
  input  logic [NUM_LANES*XLEN-1:0] denom_in,
  input  logic [TAG_WIDTH-1:0]      tag_in,
  output logic                      valid_out,
  input  logic                      ready_out,
  output logic [NUM_LANES*XLEN-1:0] result_out,
  output logic [TAG_WIDTH-1:0]      tag_out,
  output logic                      busy_out
);

  localparam int IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam int CW = $clog2(XLEN);
  localparam int FW = $clog2(NUM_UNITS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  // Per-unit control
  logic [1:0]           r_state [NUM_UNITS];
  logic [CW-1:0]        r_cnt   [NUM_UNITS];
  logic                 r_sgn   [NUM_UNITS];
  logic                 r_isrem [NUM_UNITS];
  logic [TAG_WIDTH-1:0] r_tag   [NUM_UNITS];

  // Per-unit, per-lane datapath
  logic [XLEN-1:0] r_quo   [NUM_UNITS][NUM_LANES];
  logic [XLEN-1:0] r_rem   [NUM_UNITS][NUM_LANES];
  logic [XLEN-1:0] r_dmag  [NUM_UNITS][NUM_LANES];
  logic [XLEN-1:0] r_numer [NUM_UNITS][NUM_LANES];
  logic            r_nneg  [NUM_UNITS][NUM_LANES];
  logic            r_dneg  [NUM_UNITS][NUM_LANES];
  logic            r_dz    [NUM_UNITS][NUM_LANES];
  logic            r_ovf   [NUM_UNITS][NUM_LANES];

  // Order FIFO
  logic [IW-1:0] r_fifo [NUM_UNITS];
  logic [IW-1:0] r_wptr;
  logic [IW-1:0] r_rptr;
  logic [FW-1:0] r_count;

  logic          w_found;
  logic          w_busy_any;
  logic [IW-1:0] w_sel;
  logic          w_push;
  logic          w_pop;
  logic [IW-1:0] w_head;

  logic [XLEN-1:0] w_nraw [NUM_LANES];
  logic [XLEN-1:0] w_draw [NUM_LANES];
  logic [XLEN-1:0] w_nmag [NUM_LANES];
  logic [XLEN-1:0] w_dmag [NUM_LANES];
  logic            w_nneg [NUM_LANES];
  logic            w_dneg [NUM_LANES];
  logic            w_dz   [NUM_LANES];
  logic            w_ovf  [NUM_LANES];
  logic            w_allz;

  logic [XLEN:0]   w_sh   [NUM_UNITS][NUM_LANES];
  logic [XLEN:0]   w_diff [NUM_UNITS][NUM_LANES];

  logic [XLEN-1:0] w_q [NUM_LANES];
  logic [XLEN-1:0] w_r [NUM_LANES];

  always_comb begin
    w_found    = 1'b0;
    w_busy_any = 1'b0;
    w_sel      = '0;
    for (int unsigned u = 0; u < NUM_UNITS; u++) begin
      if (r_state[u] != S_IDLE) begin
        w_busy_any = 1'b1;
      end else if (!w_found) begin
        w_found = 1'b1;
        w_sel   = IW'(u);
      end
    end
  end

  assign ready_in = w_found;
  assign busy_out = w_busy_any;
  assign w_push   = valid_in && w_found;
  assign w_head   = r_fifo[r_rptr];
  assign valid_out = (r_count != '0) && (r_state[w_head] == S_DONE);
  assign w_pop    = valid_out && ready_out;
  assign tag_out  = r_tag[w_head];

  always_comb begin
    w_allz = 1'b1;
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      w_nraw[l] = numer_in[l*XLEN +: XLEN];
      w_draw[l] = denom_in[l*XLEN +: XLEN];
      w_nneg[l] = is_signed_in && w_nraw[l][XLEN-1];
      w_dneg[l] = is_signed_in && w_draw[l][XLEN-1];
      w_nmag[l] = w_nneg[l] ? ('0 - w_nraw[l]) : w_nraw[l];
      w_dmag[l] = w_dneg[l] ? ('0 - w_draw[l]) : w_draw[l];
      w_dz[l]   = (w_draw[l] == '0);
      w_ovf[l]  = is_signed_in && (w_nraw[l] == MIN_NEG) && (w_draw[l] == '1);
      w_allz    = w_allz && w_dz[l];
    end
  end

  // r_quo starts as the dividend magnitude and shifts left as quotient bits enter
  always_comb begin
    for (int unsigned u = 0; u < NUM_UNITS; u++) begin
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
        w_sh[u][l]   = {r_rem[u][l], r_quo[u][l][XLEN-1]};
        w_diff[u][l] = w_sh[u][l] - {1'b0, r_dmag[u][l]};
      end
    end
  end

  always_comb begin
    for (int unsigned l = 0; l < NUM_LANES; l++) begin
      w_q[l] = r_quo[w_head][l];
      w_r[l] = r_rem[w_head][l];
      if (r_sgn[w_head]) begin
        if (r_nneg[w_head][l] ^ r_dneg[w_head][l]) w_q[l] = '0 - w_q[l];
        if (r_nneg[w_head][l]) w_r[l] = '0 - w_r[l];
      end
      if (r_dz[w_head][l]) begin
        w_q[l] = '1;
        w_r[l] = r_numer[w_head][l];
      end else if (r_ovf[w_head][l]) begin
        w_q[l] = r_numer[w_head][l];
        w_r[l] = '0;
      end
      result_out[l*XLEN +: XLEN] = r_isrem[w_head] ? w_r[l] : w_q[l];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned u = 0; u < NUM_UNITS; u++) begin
        r_state[u] <= S_IDLE;
        r_cnt[u]   <= '0;
        r_fifo[u]  <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      for (int unsigned u = 0; u < NUM_UNITS; u++) begin
        case (r_state[u])
          S_IDLE: begin
            if (w_push && (w_sel == IW'(u))) begin
              r_state[u] <= w_allz ? S_DONE : S_BUSY;
              r_cnt[u]   <= '0;
            end
          end
          S_BUSY: begin
            r_cnt[u] <= r_cnt[u] + CW'(1);
            if (r_cnt[u] == CW'(XLEN-1)) r_state[u] <= S_DONE;
          end
          S_DONE: begin
            if (w_pop && (w_head == IW'(u))) r_state[u] <= S_IDLE;
          end
          default: r_state[u] <= S_IDLE;
        endcase
      end
      if (w_push) begin
        r_fifo[r_wptr] <= w_sel;
        r_wptr <= (r_wptr == IW'(NUM_UNITS-1)) ? '0 : r_wptr + IW'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == IW'(NUM_UNITS-1)) ? '0 : r_rptr + IW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + FW'(1);
        2'b01:   r_count <= r_count - FW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned u = 0; u < NUM_UNITS; u++) begin
      if ((r_state[u] == S_IDLE) && w_push && (w_sel == IW'(u))) begin
        r_sgn[u]   <= is_signed_in;
        r_isrem[u] <= is_rem_in;
        r_tag[u]   <= tag_in;
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
          r_quo[u][l]   <= w_nmag[l];
          r_rem[u][l]   <= '0;
          r_dmag[u][l]  <= w_dmag[l];
          r_numer[u][l] <= w_nraw[l];
          r_nneg[u][l]  <= w_nneg[l];
          r_dneg[u][l]  <= w_dneg[l];
          r_dz[u][l]    <= w_dz[l];
          r_ovf[u][l]   <= w_ovf[l];
        end
      end else if (r_state[u] == S_BUSY) begin
        for (int unsigned l = 0; l < NUM_LANES; l++) begin
          if (!w_diff[u][l][XLEN]) begin
            r_rem[u][l] <= w_diff[u][l][XLEN-1:0];
            r_quo[u][l] <= {r_quo[u][l][XLEN-2:0], 1'b1};
          end else begin
            r_rem[u][l] <= w_sh[u][l][XLEN-1:0];
            r_quo[u][l] <= {r_quo[u][l][XLEN-2:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vx_div_pool.sv
// Directed bench for vx_div_pool: scoreboard of expected results plus latency/ordering checks.
module tb_vx_div_pool;
  localparam int XLEN = 32;
  localparam int NL   = 4;
  localparam int NU   = 2;
  localparam int TW   = 16;

  logic               clk = 1'b0;
  logic               reset;
  logic               valid_in;
  logic               ready_in;
  logic               is_signed_in;
  logic               is_rem_in;
  logic [NL*XLEN-1:0] numer_in;
  logic [NL*XLEN-1:0] denom_in;
  logic [TW-1:0]      tag_in;
  logic               valid_out;
  logic               ready_out;
  logic [NL*XLEN-1:0] result_out;
  logic [TW-1:0]      tag_out;
  logic               busy_out;

  vx_div_pool #(.XLEN(XLEN), .NUM_LANES(NL), .NUM_UNITS(NU), .TAG_WIDTH(TW)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
    .is_signed_in(is_signed_in), .is_rem_in(is_rem_in),
    .numer_in(numer_in), .denom_in(denom_in), .tag_in(tag_in),
    .valid_out(valid_out), .ready_out(ready_out), .result_out(result_out),
    .tag_out(tag_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NL*XLEN-1:0] res;
    logic [TW-1:0]      tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_pops = 0;
  int   pop_a_edge = -1;
  int   pop_b_edge = -1;
  int   acc_cyc;
  int   lat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [NL*XLEN-1:0] obs, input logic [NL*XLEN-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] ref_lane(input logic sgn, input logic rem,
                                                input logic [XLEN-1:0] n, input logic [XLEN-1:0] d);
    logic [XLEN-1:0] q, r;
    if (d == 0) begin
      q = '1; r = n;
    end else if (sgn && n == 32'h8000_0000 && d == 32'hFFFF_FFFF) begin
      q = n; r = 0;
    end else if (sgn) begin
      q = $signed(n) / $signed(d);
      r = $signed(n) % $signed(d);
    end else begin
      q = n / d;
      r = n % d;
    end
    return rem ? r : q;
  endfunction

  function automatic logic [NL*XLEN-1:0] ref_vec(input logic sgn, input logic rem,
                                                 input logic [NL*XLEN-1:0] n, input logic [NL*XLEN-1:0] d);
    logic [NL*XLEN-1:0] v;
    for (int l = 0; l < NL; l++) v[l*XLEN +: XLEN] = ref_lane(sgn, rem, n[l*XLEN +: XLEN], d[l*XLEN +: XLEN]);
    return v;
  endfunction

  // Output monitor: every transfer is matched against the oldest expected result
  always @(negedge clk) begin
    if (valid_out && ready_out) begin
      if (sb.size() == 0) begin
        chk("spurious_out", {{(NL*XLEN-1){1'b0}}, valid_out}, '0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_result", result_out, e.res);
        chk("sb_tag", {{(NL*XLEN-TW){1'b0}}, tag_out}, {{(NL*XLEN-TW){1'b0}}, e.tag});
      end
      n_pops++;
      if (tag_out === 16'h0011) pop_a_edge = cyc + 1;
      if (tag_out === 16'h0022) pop_b_edge = cyc + 1;
    end
  end

  // Drive one request, wait (bounded) for acceptance; returns at #1 after the accept edge
  task automatic issue(input logic sgn, input logic rem, input logic [NL*XLEN-1:0] n,
                       input logic [NL*XLEN-1:0] d, input logic [TW-1:0] tag, output int acc);
    exp_t e;
    int   waited;
    is_signed_in = sgn; is_rem_in = rem; numer_in = n; denom_in = d; tag_in = tag;
    valid_in = 1'b1;
    waited = 0;
    while (!ready_in && waited < 300) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!ready_in) chk("accept_timeout", {{(NL*XLEN-1){1'b0}}, ready_in}, 1);
    acc = cyc + 1;
    e.res = ref_vec(sgn, rem, n, d);
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_valid(input int acc, output int latency);
    int i;
    i = 0;
    while (!valid_out && i < 200) begin
      @(posedge clk); #1;
      i++;
    end
    if (!valid_out) chk("valid_timeout", {{(NL*XLEN-1){1'b0}}, valid_out}, 1);
    latency = cyc - acc + 1;
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 300) begin
      @(posedge clk); #1;
      i++;
    end
    chk("drain_timeout", 128'(sb.size()), 0);
  endtask

  initial begin
    int pops0;
    int acc_a, acc_b, acc_c;
    logic [NL*XLEN-1:0] n, d, e;

    reset = 1'b1; valid_in = 1'b0; ready_out = 1'b1;
    is_signed_in = 1'b0; is_rem_in = 1'b0; numer_in = '0; denom_in = '0; tag_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_valid_out", 128'(valid_out), 0);
    chk("rst_busy_out", 128'(busy_out), 0);
    chk("rst_ready_in", 128'(ready_in), 1);

    // Unsigned DIVU / REMU
    n = {4{32'd100}}; d = {4{32'd7}};
    issue(1'b0, 1'b0, n, d, 16'h0001, acc_cyc);
    wait_valid(acc_cyc, lat);
    chk("divu_latency", 128'(lat), 33);
    chk("divu_value", result_out, {4{32'd14}});
    drain();
    issue(1'b0, 1'b1, n, d, 16'h0002, acc_cyc);
    wait_valid(acc_cyc, lat);
    chk("remu_value", result_out, {4{32'd2}});
    drain();

    // Signed DIV / REM incl. overflow lane (lane 0 is lowest slice)
    n = {32'h8000_0000, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FFF9};
    d = {32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd2};
    issue(1'b1, 1'b0, n, d, 16'h0003, acc_cyc);
    wait_valid(acc_cyc, lat);
    chk("div_signed", result_out, {32'h8000_0000, 32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFD});
    drain();
    issue(1'b1, 1'b1, n, d, 16'h0004, acc_cyc);
    wait_valid(acc_cyc, lat);
    chk("rem_signed", result_out, {32'd0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF});
    drain();

    // Early-out and mixed zero-divisor lanes
    n = {4{32'd5}}; d = '0;
    issue(1'b0, 1'b0, n, d, 16'h0005, acc_cyc);
    wait_valid(acc_cyc, lat);
    chk("early_latency", 128'(lat), 1);
    chk("early_div", result_out, {4{32'hFFFF_FFFF}});
    drain();
    issue(1'b1, 1'b1, n, d, 16'h0006, acc_cyc);
    wait_valid(acc_cyc, lat);
    chk("early_rem", result_out, {4{32'd5}});
    drain();
    n = {4{32'd9}}; d = {32'd3, 32'd3, 32'd3, 32'd0};
    issue(1'b0, 1'b0, n, d, 16'h0007, acc_cyc);
    wait_valid(acc_cyc, lat);
    chk("mixed_latency", 128'(lat), 33);
    chk("mixed_value", result_out, {32'd3, 32'd3, 32'd3, 32'hFFFF_FFFF});
    drain();

    // Ordering: normal A then early-out B; third request C stalls until A pops
    issue(1'b0, 1'b0, {4{32'd1000}}, {4{32'd10}}, 16'h0011, acc_a);
    issue(1'b0, 1'b0, {4{32'd1}}, '0, 16'h0022, acc_b);
    chk("order_ready_low", 128'(ready_in), 0);
    chk("order_busy", 128'(busy_out), 1);
    chk("order_b_waits", 128'(valid_out), 0);
    issue(1'b1, 1'b1, {4{32'hFFFF_FF9C}}, {4{32'd7}}, 16'h0033, acc_c);
    chk("order_c_after_pop", 128'(acc_c), 128'(pop_a_edge + 1));
    chk("order_b_next", 128'(pop_b_edge), 128'(pop_a_edge + 1));
    drain();

    // Backpressure: hold ready_out low for 10 cycles once valid_out rises
    ready_out = 1'b0;
    pops0 = n_pops;
    n = {32'd77, 32'd1, 32'hFFFF_FFFF, 32'd12345};
    d = {32'd5, 32'd3, 32'd16, 32'd0};
    e = ref_vec(1'b0, 1'b0, n, d);
    issue(1'b0, 1'b0, n, d, 16'h0055, acc_cyc);
    issue(1'b0, 1'b1, {4{32'd8}}, '0, 16'h0066, acc_b);
    wait_valid(acc_cyc, lat);
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", 128'(valid_out), 1);
      chk("bp_result", result_out, e);
      chk("bp_tag", 128'(tag_out), 128'(16'h0055));
      @(posedge clk); #1;
    end
    ready_out = 1'b1;
    drain();
    repeat (3) @(posedge clk);
    #1;
    chk("bp_pop_count", 128'(n_pops - pops0), 2);
    chk("bp_valid_low", 128'(valid_out), 0);

    // Reset with two ops in flight
    issue(1'b0, 1'b0, {4{32'd50}}, {4{32'd6}}, 16'h0077, acc_a);
    issue(1'b0, 1'b0, {4{32'd60}}, {4{32'd6}}, 16'h0088, acc_b);
    repeat (5) @(posedge clk);
    #1;
    ready_out = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    pops0 = n_pops;
    chk("midrst_valid_out", 128'(valid_out), 0);
    chk("midrst_busy_out", 128'(busy_out), 0);
    chk("midrst_ready_in", 128'(ready_in), 1);
    ready_out = 1'b1;
    issue(1'b1, 1'b0, {4{32'hFFFF_FFE0}}, {4{32'd3}}, 16'h0099, acc_cyc);
    drain();
    repeat (40) @(posedge clk);
    #1;
    chk("post_rst_pops", 128'(n_pops - pops0), 1);
    chk("post_rst_idle", 128'(busy_out), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
